// File: rtl/potential_accumulator.sv
// potential_accumulator: loads a neuron's decayed FP32 membrane potential at
// timestep start, adds each synaptic weight through a valid/ready handshake,
// and at timestep end compares against threshold. It returns the next
// potential (V_RESET on spike) with a one-cycle potential_valid pulse.
// Also contains the combinational FP32 adder Addition_Subtraction used here.

module potential_accumulator #(
    parameter logic [31:0] V_THRESHOLD = 32'h41F00000,  // 30.0, must be positive
    parameter logic [31:0] V_RESET     = 32'h00000000   // 0.0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        timestep_start,
    input  logic [31:0] decayed_potential,
    input  logic        weight_valid,
    input  logic [31:0] weight,
    output logic        weight_ready,
    input  logic        timestep_end,
    output logic [31:0] new_potential,
    output logic        potential_valid,
    output logic        spike,
    output logic [7:0]  weight_count,
    output logic        exception,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] ADD    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] operand_q, operand_d;
    logic [7:0]  count_q, count_d;
    logic        exc_q, exc_d;
    logic        end_pending_q, end_pending_d;
    logic [31:0] new_pot_q, new_pot_d;
    logic        pv_q, pv_d;
    logic        spike_q, spike_d;

    logic [31:0] add_result;
    logic        add_exc;
    logic        ge;

    Addition_Subtraction u_adder (
        .a              (acc_q),
        .b              (operand_q),
        .add_sub_signal (1'b0),
        .Exception      (add_exc),
        .result         (add_result)
    );

    // Sign-magnitude compare: a positive FP32 orders like its unsigned
    // magnitude bits, and negative or zero sums never reach a positive threshold.
    assign ge = !acc_q[31] && (acc_q[30:0] >= V_THRESHOLD[30:0]);

    // A weight is taken only while accumulating and no close is requested.
    assign weight_ready = (state_q == ACCUM) && !timestep_end && !end_pending_q;

    assign busy            = (state_q != IDLE);
    assign new_potential   = new_pot_q;
    assign potential_valid = pv_q;
    assign spike           = spike_q;
    assign weight_count    = count_q;
    assign exception       = exc_q;

    // Next-state and datapath decode for the accumulate FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d       = state_q;
        acc_d         = acc_q;
        operand_d     = operand_q;
        count_d       = count_q;
        exc_d         = exc_q;
        end_pending_d = end_pending_q;
        new_pot_d     = new_pot_q;
        pv_d          = 1'b0;
        spike_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (timestep_start) begin
                    acc_d   = decayed_potential;
                    count_d = 8'd0;
                    exc_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Closing the timestep wins over a weight offered the same cycle.
                if (timestep_end || end_pending_q) begin
                    state_d = FINISH;
                end else if (weight_valid) begin
                    operand_d = weight;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d   = add_result;
                exc_d   = exc_q | add_exc;
                if (timestep_end) end_pending_d = 1'b1;
                state_d = ACCUM;
            end
            FINISH: begin
                new_pot_d     = ge ? V_RESET : acc_q;
                spike_d       = ge;
                pv_d          = 1'b1;
                end_pending_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; a reset discards any partial sum.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from values sampled before the edge.
        if (reset) begin
            state_q       <= IDLE;
            acc_q         <= 32'd0;
            operand_q     <= 32'd0;
            count_q       <= 8'd0;
            exc_q         <= 1'b0;
            end_pending_q <= 1'b0;
            new_pot_q     <= 32'd0;
            pv_q          <= 1'b0;
            spike_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            operand_q     <= operand_d;
            count_q       <= count_d;
            exc_q         <= exc_d;
            end_pending_q <= end_pending_d;
            new_pot_q     <= new_pot_d;
            pv_q          <= pv_d;
            spike_q       <= spike_d;
        end
    end

endmodule

// Combinational IEEE-754 single-precision add/subtract, round to nearest even,
// with subnormal support. Exception flags an Inf/NaN operand or an overflow.
module Addition_Subtraction (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_sub_signal,
    output logic        Exception,
    output logic [31:0] result
);

    function automatic logic [4:0] clz27(input logic [26:0] v);
        clz27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) clz27 = 5'(26 - i);
        end
    endfunction

    logic [31:0] b_eff, x, y;
    logic [9:0]  exn, eyn, d, sh, e, ef;
    logic [4:0]  dc, lz;
    logic [23:0] mx, my;
    logic [55:0] y_wide;
    logic [26:0] x_al, y_al, norm;
    logic [27:0] raw;
    logic [24:0] mant;
    logic        round_up;

    // Order operands so x has the larger magnitude; the difference then
    // never goes negative and the result takes x's sign.
    assign b_eff = {b[31] ^ add_sub_signal, b[30:0]};
    assign x     = (b_eff[30:0] > a[30:0]) ? b_eff : a;
    assign y     = (b_eff[30:0] > a[30:0]) ? a : b_eff;

    // Align, add/subtract, normalise, round and handle specials.
    always_comb begin
        Exception = 1'b0;
        exn = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        eyn = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        mx  = {x[30:23] != 8'd0, x[22:0]};
        my  = {y[30:23] != 8'd0, y[22:0]};
        d   = exn - eyn;
        dc  = (d > 10'd31) ? 5'd31 : d[4:0];
        // Bits shifted below the guard/round pair collapse into a sticky bit.
        y_wide = {my, 32'd0} >> dc;
        y_al   = {y_wide[55:30], |y_wide[29:0]};
        x_al   = {mx, 3'b000};
        if (x[31] == y[31]) raw = {1'b0, x_al} + {1'b0, y_al};
        else                raw = {1'b0, x_al} - {1'b0, y_al};

        lz = clz27(raw[26:0]);
        sh = 10'd0;
        if (raw[27]) begin
            norm = {raw[27:2], raw[1] | raw[0]};
            e    = exn + 10'd1;
        end else begin
            // Stop shifting at exponent 1 so tiny results become subnormal.
            sh   = ({5'd0, lz} < exn) ? {5'd0, lz} : exn - 10'd1;
            norm = raw[26:0] << sh;
            e    = exn - sh;
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant[24])      ef = e + 10'd1;
        else if (mant[23]) ef = e;
        else               ef = 10'd0;

        if (raw == 28'd0) begin
            result = {x[31] & y[31], 31'd0};
        end else if (ef >= 10'd255) begin
            result    = {x[31], 8'hFF, 23'd0};
            Exception = 1'b1;
        end else begin
            result = {x[31], ef[7:0], mant[22:0]};
        end

        // x carries any NaN because NaN outranks every other magnitude.
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            Exception = 1'b1;
            if (x[22:0] != 23'd0 || (y[30:23] == 8'hFF && x[31] != y[31]))
                result = 32'h7FC00000;
            else
                result = {x[31], 8'hFF, 23'd0};
        end
    end

endmodule

// File: tb/tb_potential_accumulator.sv
// Directed bench for potential_accumulator with hand-computed FP32 results.

module tb_potential_accumulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        timestep_start;
    logic [31:0] decayed_potential;
    logic        weight_valid;
    logic [31:0] weight;
    logic        weight_ready;
    logic        timestep_end;
    logic [31:0] new_potential;
    logic        potential_valid;
    logic        spike;
    logic [7:0]  weight_count;
    logic        exception;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] F_ONE = 32'h3F800000;
    localparam logic [31:0] F_TWO = 32'h40000000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_INF = 32'h7F800000;

    potential_accumulator dut (
        .clock             (clock),
        .reset             (reset),
        .timestep_start    (timestep_start),
        .decayed_potential (decayed_potential),
        .weight_valid      (weight_valid),
        .weight            (weight),
        .weight_ready      (weight_ready),
        .timestep_end      (timestep_end),
        .new_potential     (new_potential),
        .potential_valid   (potential_valid),
        .spike             (spike),
        .weight_count      (weight_count),
        .exception         (exception),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_ts(input logic [31:0] val);
        timestep_start    = 1'b1;
        decayed_potential = val;
        step();
        timestep_start    = 1'b0;
    endtask

    // Offer one weight, wait (bounded) for ready, then let the add complete.
    task automatic accept(input string tag, input logic [31:0] w);
        int i = 0;
        weight_valid = 1'b1;
        weight       = w;
        #1;
        while (!weight_ready && i < 8) begin
            step();
            i++;
        end
        check({tag, "_ready"}, {31'd0, weight_ready}, 32'd1);
        step();
        weight_valid = 1'b0;
        check({tag, "_ready_add"}, {31'd0, weight_ready}, 32'd0);
        step();
    endtask

    // Pulse timestep_end from ACCUM and check the result pulse lands at T+2.
    task automatic close(input string tag, input logic [31:0] pot, input logic spk,
                         input logic [7:0] cnt, input logic exc);
        timestep_end = 1'b1;
        step();
        timestep_end = 1'b0;
        check({tag, "_pv_t1"}, {31'd0, potential_valid}, 32'd0);
        step();
        check({tag, "_pv_t2"}, {31'd0, potential_valid}, 32'd1);
        check({tag, "_spike"}, {31'd0, spike}, {31'd0, spk});
        check({tag, "_pot"}, new_potential, pot);
        check({tag, "_count"}, {24'd0, weight_count}, {24'd0, cnt});
        check({tag, "_exc"}, {31'd0, exception}, {31'd0, exc});
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        step();
        check({tag, "_pv_t3"}, {31'd0, potential_valid}, 32'd0);
        check({tag, "_pot_hold"}, new_potential, pot);
    endtask

    initial begin
        reset = 1'b1; timestep_start = 1'b0; decayed_potential = 32'd0;
        weight_valid = 1'b0; weight = 32'd0; timestep_end = 1'b0;
        step(); step();
        check("rst_pot", new_potential, 32'd0);
        check("rst_pv", {31'd0, potential_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, weight_ready}, 32'd0);
        reset = 1'b0;
        step();

        // 13.92 + 1 + 1 = 15.92, below threshold
        start_ts(32'h415EB852);
        check("t1_busy", {31'd0, busy}, 32'd1);
        accept("t1_w0", F_ONE);
        accept("t1_w1", F_ONE);
        close("t1", 32'h417EB852, 1'b0, 8'd2, 1'b0);

        // 27.84 + 3 = 30.84 fires
        start_ts(32'h41DEB852);
        accept("t2_w0", F_3);
        close("t2", 32'h00000000, 1'b1, 8'd1, 1'b0);

        // 27 + 3 = 30 exactly fires
        start_ts(32'h41D80000);
        accept("t3_w0", F_3);
        close("t3", 32'h00000000, 1'b1, 8'd1, 1'b0);

        // -10 + 20 = 10, no spike
        start_ts(32'hC1200000);
        accept("t4_w0", 32'h41A00000);
        close("t4", 32'h41200000, 1'b0, 8'd1, 1'b0);

        // zero weights: below and above threshold
        start_ts(32'h40A00000);
        close("t5a", 32'h40A00000, 1'b0, 8'd0, 1'b0);
        start_ts(32'h42000000);
        close("t5b", 32'h00000000, 1'b1, 8'd0, 1'b0);

        // negative start, zero weights: never spikes
        start_ts(32'hC2000000);
        close("t5c", 32'hC2000000, 1'b0, 8'd0, 1'b0);

        // timestep_start while accumulating is ignored
        start_ts(F_TWO);
        timestep_start = 1'b1; decayed_potential = 32'h42C80000;
        step();
        timestep_start = 1'b0;
        accept("t6_w0", F_ONE);
        close("t6", F_3, 1'b0, 8'd1, 1'b0);

        // end and valid together: weight refused, not counted
        start_ts(F_ONE);
        weight_valid = 1'b1; weight = F_TWO; timestep_end = 1'b1;
        #1;
        check("t7_ready", {31'd0, weight_ready}, 32'd0);
        step();
        weight_valid = 1'b0; timestep_end = 1'b0;
        check("t7_pv_t1", {31'd0, potential_valid}, 32'd0);
        step();
        check("t7_pv_t2", {31'd0, potential_valid}, 32'd1);
        check("t7_pot", new_potential, F_ONE);
        check("t7_count", {24'd0, weight_count}, 32'd0);

        // end during ADD: add completes, then FINISH
        start_ts(F_ONE);
        weight_valid = 1'b1; weight = F_TWO;
        step();
        weight_valid = 1'b0; timestep_end = 1'b1;
        step();
        timestep_end = 1'b0;
        #1;
        check("t8_ready_pending", {31'd0, weight_ready}, 32'd0);
        check("t8_pv_a", {31'd0, potential_valid}, 32'd0);
        step();
        check("t8_pv_b", {31'd0, potential_valid}, 32'd0);
        step();
        check("t8_pv", {31'd0, potential_valid}, 32'd1);
        check("t8_pot", new_potential, F_3);
        check("t8_count", {24'd0, weight_count}, 32'd1);
        step();

        // reset while in ADD after three weights
        start_ts(F_ONE);
        accept("t9_w0", F_ONE);
        accept("t9_w1", F_ONE);
        weight_valid = 1'b1; weight = F_ONE;
        step();
        weight_valid = 1'b0;
        check("t9_count_pre", {24'd0, weight_count}, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t9_pot", new_potential, 32'd0);
        check("t9_count", {24'd0, weight_count}, 32'd0);
        check("t9_busy", {31'd0, busy}, 32'd0);
        check("t9_ready", {31'd0, weight_ready}, 32'd0);
        check("t9_pv", {31'd0, potential_valid}, 32'd0);
        step();
        start_ts(F_ONE);
        close("t9b", F_ONE, 1'b0, 8'd0, 1'b0);

        // Inf weight: sticky exception until the next timestep_start
        start_ts(F_ONE);
        accept("t10_w0", F_INF);
        check("t10_exc_add", {31'd0, exception}, 32'd1);
        close("t10", 32'h00000000, 1'b1, 8'd1, 1'b1);
        check("t10_exc_held", {31'd0, exception}, 32'd1);
        start_ts(F_ONE);
        check("t10_exc_clear", {31'd0, exception}, 32'd0);
        close("t10b", F_ONE, 1'b0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
